alu_op_decode: RTL and testbench

Registered decode stage that turns an RV32I integer instruction plus its source operands into the ALU's inputs: operand A, operand B and the 4-bit `alu_sel` code. It sits between register-file read and the execute stage. It is the producer side of the ALU's `a`/`b`/`alu_sel` interface. Both sides use valid/ready handshakes, and a two-entry skid buffer keeps `in_ready` registered.

---
 rtl/alu_op_decode_pkg.sv | 68 ++++++
 rtl/alu_op_decode_pipe_skid_buf.sv | 86 ++++++++
 rtl/alu_op_decode.sv | 131 +++++++++++++
 tb/tb_alu_op_decode.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_decode_pkg.sv
// Shared types for the RV32I integer decode stage and the ALU it feeds.
package alu_op_decode_pkg;

  localparam int DATA_WIDTH = 32;

  // ALU operation codes, shared with the execute stage.
  typedef enum logic [3:0] {
    ALU_ADD     = 4'h0,
    ALU_SUB     = 4'h1,
    ALU_SLL     = 4'h2,
    ALU_SLT     = 4'h3,
    ALU_SLTU    = 4'h4,
    ALU_XOR     = 4'h5,
    ALU_SRL     = 4'h6,
    ALU_SRA     = 4'h7,
    ALU_OR      = 4'h8,
    ALU_AND     = 4'h9,
    ALU_NOP     = 4'hE,
    ALU_INVALID = 4'hF
  } alu_sel_t;

  // RV32I major opcodes handled by this stage.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct7 values that select the base or the alternate (SUB/SRA) operation.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // One decoded entry as it travels through the skid buffer.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    alu_sel_t              alu_sel;
    logic [4:0]            rd;
    logic                  rd_we;
    logic                  illegal;
  } alu_payload_t;

  localparam alu_payload_t PAYLOAD_RESET = '{
    a:       '0,
    b:       '0,
    alu_sel: ALU_NOP,
    rd:      '0,
    rd_we:   1'b0,
    illegal: 1'b0
  };

  // Base operation selected by funct3 (funct7 variants are resolved by the caller).
  function automatic alu_sel_t alu_sel_from_funct3(input logic [2:0] funct3);
    alu_sel_t sel;
    sel = ALU_ADD;
    case (funct3)
      3'b000:  sel = ALU_ADD;
      3'b001:  sel = ALU_SLL;
      3'b010:  sel = ALU_SLT;
      3'b011:  sel = ALU_SLTU;
      3'b100:  sel = ALU_XOR;
      3'b101:  sel = ALU_SRL;
      3'b110:  sel = ALU_OR;
      default: sel = ALU_AND;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_op_decode_pipe_skid_buf.sv
// Generic two-entry valid/ready buffer: an output register plus one skid
// register, so in_ready comes straight from a flop.
module pipe_skid_buf #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             drain;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // Occupancy FSM with registered handshake outputs and the two data slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      // NOTE: both data slots take a defined reset value; the output slot is
      // architecturally visible after reset and the skid slot just keeps X
      // out of simulation.
      out_data  <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else if (flush) begin
      state     <= S_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // the FULL->ONE skid-to-output move relies on that.
      case (state)
        S_EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && !drain) begin
            skid_data <= in_data;
            in_ready  <= 1'b0;
            state     <= S_FULL;
          end else if (accept && drain) begin
            out_data <= in_data;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (drain) begin
            out_data <= skid_data;
            in_ready <= 1'b1;
            state    <= S_ONE;
          end
        end
        default: begin
          state     <= S_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_op_decode.sv
// Registered RV32I decode stage: turns an instruction and its source operands
// into ALU operand A, operand B and alu_sel, behind a two-entry skid buffer.
module alu_op_decode
  import alu_op_decode_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [3:0]            out_alu_sel,
  output logic [4:0]            out_rd,
  output logic                  out_rd_we,
  output logic                  out_illegal
);

  // Combinational decode of one instruction beat into an ALU payload.
  function automatic alu_payload_t decode(
    input logic [31:0]           instr,
    input logic [DATA_WIDTH-1:0] pc,
    input logic [DATA_WIDTH-1:0] rs1,
    input logic [DATA_WIDTH-1:0] rs2
  );
    alu_payload_t          p;
    logic [6:0]            opcode;
    logic [6:0]            funct7;
    logic [2:0]            funct3;
    logic                  legal;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_u;

    // NOTE: blocking assignments with a full default set first; this is pure
    // combinational evaluation and no path may leave a field unassigned.
    opcode    = instr[6:0];
    funct3    = instr[14:12];
    funct7    = instr[31:25];
    imm_i     = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    imm_u     = {instr[31:12], 12'b0};
    legal     = 1'b1;
    p         = PAYLOAD_RESET;
    p.a       = rs1;
    p.b       = rs2;
    p.alu_sel = alu_sel_from_funct3(funct3);

    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_ALT && funct3 == 3'b000) begin
          p.alu_sel = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          p.alu_sel = ALU_SRA;
        end else if (funct7 != F7_BASE) begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        p.b = imm_i;
        if (funct3 == 3'b001) begin
          legal = (funct7 == F7_BASE);
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) begin
            p.alu_sel = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            legal = 1'b0;
          end
        end
      end
      OPC_LUI: begin
        p.a       = '0;
        p.b       = imm_u;
        p.alu_sel = ALU_ADD;
      end
      OPC_AUIPC: begin
        p.a       = pc;
        p.b       = imm_u;
        p.alu_sel = ALU_ADD;
      end
      default: legal = 1'b0;
    endcase

    // Undecodable beats still carry the raw operands for diagnostics.
    if (!legal) begin
      p.a       = rs1;
      p.b       = rs2;
      p.alu_sel = ALU_INVALID;
    end

    p.rd      = instr[11:7];
    p.rd_we   = legal && (instr[11:7] != 5'd0);
    p.illegal = !legal;
    return p;
  endfunction

  alu_payload_t in_payload;
  alu_payload_t out_payload;

  // Decode the presented beat every cycle; the buffer captures it on accept.
  always_comb begin
    in_payload = decode(in_instr, in_pc, in_rs1_data, in_rs2_data);
  end

  pipe_skid_buf #(
    .WIDTH     ($bits(alu_payload_t)),
    .RESET_VAL (PAYLOAD_RESET)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign out_a       = out_payload.a;
  assign out_b       = out_payload.b;
  assign out_alu_sel = out_payload.alu_sel;
  assign out_rd      = out_payload.rd;
  assign out_rd_we   = out_payload.rd_we;
  assign out_illegal = out_payload.illegal;

endmodule

// File: tb/tb_alu_op_decode.sv
// Self-checking bench for alu_op_decode: directed decode vectors, stall,
// flush and reset sequences, and a randomized handshake run against a model.
module tb_alu_op_decode;
  import alu_op_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_alu_sel;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_decode dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_alu_sel (out_alu_sel),
    .out_rd      (out_rd),
    .out_rd_we   (out_rd_we),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] a;
    logic [31:0] b;
    alu_sel_t    sel;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add_vec(input logic [31:0] instr, pc, rs1, rs2, a, b,
                                  input alu_sel_t sel, input logic [4:0] rd,
                                  input logic we, ill);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.a = a; v.b = b; v.sel = sel; v.rd = rd; v.we = we; v.ill = ill;
    vecs.push_back(v);
  endfunction

  task automatic drive_add(input logic [31:0] rs1);
    in_instr    = 32'h002081B3;
    in_pc       = 32'h0;
    in_rs1_data = rs1;
    in_rs2_data = 32'h1;
    in_valid    = 1'b1;
  endtask

  // Reference decode written as an encoding lookup, independent of the RTL form.
  function automatic logic [74:0] model(input logic [31:0] ins, pc, r1, r2);
    logic [6:0]  opc;
    logic [9:0]  key;
    logic        ok;
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    opc = ins[6:0];
    key = {ins[31:25], ins[14:12]};
    ok  = 1'b1;
    a   = r1;
    b   = r2;
    sel = ALU_INVALID;
    if (opc == 7'h33) begin
      case (key)
        {7'h00, 3'd0}: sel = ALU_ADD;
        {7'h20, 3'd0}: sel = ALU_SUB;
        {7'h00, 3'd1}: sel = ALU_SLL;
        {7'h00, 3'd2}: sel = ALU_SLT;
        {7'h00, 3'd3}: sel = ALU_SLTU;
        {7'h00, 3'd4}: sel = ALU_XOR;
        {7'h00, 3'd5}: sel = ALU_SRL;
        {7'h20, 3'd5}: sel = ALU_SRA;
        {7'h00, 3'd6}: sel = ALU_OR;
        {7'h00, 3'd7}: sel = ALU_AND;
        default:       ok  = 1'b0;
      endcase
    end else if (opc == 7'h13) begin
      b = {{20{ins[31]}}, ins[31:20]};
      case (ins[14:12])
        3'd0: sel = ALU_ADD;
        3'd1: begin sel = ALU_SLL; ok = (ins[31:25] == 7'h00); end
        3'd2: sel = ALU_SLT;
        3'd3: sel = ALU_SLTU;
        3'd4: sel = ALU_XOR;
        3'd5: begin
          if (ins[31:25] == 7'h00)      sel = ALU_SRL;
          else if (ins[31:25] == 7'h20) sel = ALU_SRA;
          else                          ok  = 1'b0;
        end
        3'd6: sel = ALU_OR;
        default: sel = ALU_AND;
      endcase
    end else if (opc == 7'h37) begin
      a = 32'h0; b = {ins[31:12], 12'h0}; sel = ALU_ADD;
    end else if (opc == 7'h17) begin
      a = pc; b = {ins[31:12], 12'h0}; sel = ALU_ADD;
    end else begin
      ok = 1'b0;
    end
    if (!ok) begin
      a = r1; b = r2; sel = ALU_INVALID;
    end
    return {a, b, sel, ins[11:7], ok && (ins[11:7] != 5'd0), !ok};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opc;
    logic [6:0]  f7;
    r = $urandom;
    case ($urandom_range(0, 5))
      0, 4:    opc = 7'h33;
      1:       opc = 7'h13;
      2:       opc = 7'h37;
      3:       opc = 7'h17;
      default: opc = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      1:       f7 = 7'h20;
      2:       f7 = 7'($urandom);
      default: f7 = 7'h00;
    endcase
    return {f7, r[24:7], opc};
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;

    // Directed decode table: instr, pc, rs1, rs2 -> a, b, sel, rd, rd_we, illegal.
    add_vec(32'h002081B3, 32'h0,   32'd5,        32'd7,  32'd5,        32'd7,        ALU_ADD,     5'd3,  1, 0); // add x3,x1,x2
    add_vec(32'h40435293, 32'h0,   32'h80000000, 32'h11, 32'h80000000, 32'h00000404, ALU_SRA,     5'd5,  1, 0); // srai x5,x6,4 (imm 0x404, shamt 4)
    add_vec(32'h20435293, 32'h0,   32'h80000000, 32'h11, 32'h80000000, 32'h11,       ALU_INVALID, 5'd5,  0, 1); // bad SRAI funct7
    add_vec(32'h12345097, 32'h100, 32'h3,        32'h4,  32'h100,      32'h12345000, ALU_ADD,     5'd1,  1, 0); // auipc x1,0x12345
    add_vec(32'h00001037, 32'h40,  32'hDEAD,     32'h4,  32'h0,        32'h00001000, ALU_ADD,     5'd0,  0, 0); // lui x0,1
    add_vec(32'h40C58533, 32'h0,   32'd20,       32'd9,  32'd20,       32'd9,        ALU_SUB,     5'd10, 1, 0); // sub x10,x11,x12
    add_vec(32'hFFF10093, 32'h0,   32'd2,        32'd8,  32'd2,        32'hFFFFFFFF, ALU_ADD,     5'd1,  1, 0); // addi x1,x2,-1
    add_vec(32'h01F21213, 32'h0,   32'd1,        32'd8,  32'd1,        32'h1F,       ALU_SLL,     5'd4,  1, 0); // slli x4,x4,31
    add_vec(32'h41F21213, 32'h0,   32'd1,        32'd8,  32'd1,        32'd8,        ALU_INVALID, 5'd4,  0, 1); // slli with funct7 0100000
    add_vec(32'h403140B3, 32'h0,   32'd6,        32'd3,  32'd6,        32'd3,        ALU_INVALID, 5'd1,  0, 1); // xor with funct7 0100000
    add_vec(32'h409453B3, 32'h0,   32'hF0,       32'd4,  32'hF0,       32'd4,        ALU_SRA,     5'd7,  1, 0); // sra x7,x8,x9
    add_vec(32'h8001B113, 32'h0,   32'd3,        32'd9,  32'd3,        32'hFFFFF800, ALU_SLTU,    5'd2,  1, 0); // sltiu x2,x3,-2048
    add_vec(32'h0010D093, 32'h0,   32'd7,        32'd9,  32'd7,        32'd1,        ALU_SRL,     5'd1,  1, 0); // srli x1,x1,1
    add_vec(32'h00002003, 32'h0,   32'd7,        32'd9,  32'd7,        32'd9,        ALU_INVALID, 5'd0,  0, 1); // lw: unsupported opcode

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst out_valid",   96'(out_valid),   96'(0));
    check("rst in_ready",    96'(in_ready),    96'(1));
    check("rst out_illegal", 96'(out_illegal), 96'(0));
    check("rst out_rd_we",   96'(out_rd_we),   96'(0));
    check("rst out_a",       96'(out_a),       96'(0));
    check("rst out_b",       96'(out_b),       96'(0));
    check("rst out_rd",      96'(out_rd),      96'(0));
    check("rst out_alu_sel", 96'(out_alu_sel), 96'(ALU_NOP));
    step();

    // Directed vectors: one beat in, check one cycle later, then drain.
    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      in_instr = vecs[i].instr; in_pc = vecs[i].pc;
      in_rs1_data = vecs[i].rs1; in_rs2_data = vecs[i].rs2;
      in_valid = 1'b1;
      check($sformatf("v%0d in_ready", i), 96'(in_ready), 96'(1));
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d out_valid", i), 96'(out_valid),   96'(1));
      check($sformatf("v%0d a", i),         96'(out_a),       96'(vecs[i].a));
      check($sformatf("v%0d b", i),         96'(out_b),       96'(vecs[i].b));
      check($sformatf("v%0d alu_sel", i),   96'(out_alu_sel), 96'(vecs[i].sel));
      check($sformatf("v%0d rd", i),        96'(out_rd),      96'(vecs[i].rd));
      check($sformatf("v%0d rd_we", i),     96'(out_rd_we),   96'(vecs[i].we));
      check($sformatf("v%0d illegal", i),   96'(out_illegal), 96'(vecs[i].ill));
      step();
      check($sformatf("v%0d drained", i),   96'(out_valid),   96'(0));
    end

    // Backpressure: three back-to-back beats with out_ready low.
    out_ready = 1'b0;
    drive_add(32'd100);
    step();
    check("bp one out_valid", 96'(out_valid), 96'(1));
    check("bp one in_ready",  96'(in_ready),  96'(1));
    check("bp one a",         96'(out_a),     96'(100));
    drive_add(32'd101);
    step();
    check("bp full in_ready", 96'(in_ready), 96'(0));
    check("bp full a",        96'(out_a),    96'(100));
    drive_add(32'd102);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp stall%0d a", k),        96'(out_a),     96'(100));
      check($sformatf("bp stall%0d in_ready", k), 96'(in_ready),  96'(0));
      check($sformatf("bp stall%0d valid", k),    96'(out_valid), 96'(1));
    end
    out_ready = 1'b1;
    step();
    check("bp skid move a",    96'(out_a),     96'(101));
    check("bp skid move rdy",  96'(in_ready),  96'(1));
    check("bp skid move vld",  96'(out_valid), 96'(1));
    step();
    in_valid = 1'b0;
    check("bp third a",        96'(out_a),     96'(102));
    check("bp third vld",      96'(out_valid), 96'(1));
    step();
    check("bp empty vld",      96'(out_valid), 96'(0));

    // Flush from FULL with a beat presented in the same cycle.
    out_ready = 1'b0;
    drive_add(32'd200);
    step();
    drive_add(32'd201);
    step();
    check("fl full in_ready", 96'(in_ready), 96'(0));
    drive_add(32'd202);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl out_valid", 96'(out_valid), 96'(0));
    check("fl in_ready",  96'(in_ready),  96'(1));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("fl after%0d out_valid", k), 96'(out_valid), 96'(0));
    end

    // Asynchronous reset with two entries held.
    out_ready = 1'b0;
    drive_add(32'd300);
    step();
    drive_add(32'd301);
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid rst out_valid", 96'(out_valid), 96'(0));
    check("mid rst in_ready",  96'(in_ready),  96'(1));
    check("mid rst out_a",     96'(out_a),     96'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    step();
    check("post rst out_valid", 96'(out_valid), 96'(0));

    // Randomized valid/ready traffic against the reference model.
    begin
      logic [74:0] q[$];
      int acc_cnt;
      int cyc;
      acc_cnt = 0;
      cyc = 0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      while (acc_cnt < 10000 && cyc < 60000) begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rnd spurious beat: got a=0x%0h expected no beat", out_a);
          end else begin
            check("rnd beat",
                  96'({out_a, out_b, out_alu_sel, out_rd, out_rd_we, out_illegal}),
                  96'(q.pop_front()));
          end
        end
        if (in_valid && in_ready) begin
          q.push_back(model(in_instr, in_pc, in_rs1_data, in_rs2_data));
          acc_cnt++;
        end
        step();
        cyc++;
        in_valid    = ($urandom_range(0, 3) != 0);
        out_ready   = ($urandom_range(0, 9) < 7);
        in_instr    = rand_instr();
        in_pc       = $urandom;
        in_rs1_data = $urandom;
        in_rs2_data = $urandom;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rnd spurious tail beat: got a=0x%0h expected no beat", out_a);
          end else begin
            check("rnd tail beat",
                  96'({out_a, out_b, out_alu_sel, out_rd, out_rd_we, out_illegal}),
                  96'(q.pop_front()));
          end
        end
        step();
      end
      check("rnd accepted", 96'(acc_cnt),  96'(10000));
      check("rnd leftover", 96'(q.size()), 96'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
